// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: each channel is synchronized, then accepted only
// after STABLE_TICKS consecutive agreeing samples taken on m_tick strobes.
module multi_debouncer #(
  parameter int N_CH         = 4,
  parameter int STABLE_TICKS = 4,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_tick,
  input  logic [N_CH-1:0] level,
  output logic [N_CH-1:0] curr_level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] TICKS_TARGET = CW'(STABLE_TICKS);

  typedef enum logic [1:0] {
    ST_LOW,
    WAIT_HIGH,
    ST_HIGH,
    WAIT_LOW
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? ST_HIGH : ST_LOW;

  logic [N_CH-1:0] lvl_m;
  logic [N_CH-1:0] lvl_s;

  state_t          state_q [N_CH];
  state_t          state_n [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_n   [N_CH];
  logic [N_CH-1:0] rise_n;
  logic [N_CH-1:0] fall_n;
  logic [N_CH-1:0] curr_n;

  // Two-flop synchronizer bringing the raw inputs into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lvl_m <= {N_CH{RESET_LEVEL}};
      lvl_s <= {N_CH{RESET_LEVEL}};
    end else begin
      lvl_m <= level;
      lvl_s <= lvl_m;
    end
  end

  // Per-channel state, counter and registered outputs; reset wins over m_tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= RESET_STATE;
        cnt_q[ch]   <= '0;
      end
      curr_level <= {N_CH{RESET_LEVEL}};
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= state_n[ch];
        cnt_q[ch]   <= cnt_n[ch];
      end
      curr_level <= curr_n;
      rise       <= rise_n;
      fall       <= fall_n;
      any_change <= |(rise_n | fall_n);
    end
  end

  // Next-state logic: count agreeing ticks, any reversal drops back with no credit.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rise_n  = '0;
    fall_n  = '0;
    curr_n  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (m_tick) begin
        case (state_q[ch])
          ST_LOW: begin
            if (lvl_s[ch]) begin
              state_n[ch] = WAIT_HIGH;
              cnt_n[ch]   = CW'(1);
            end
          end
          WAIT_HIGH: begin
            if (!lvl_s[ch]) begin
              state_n[ch] = ST_LOW;
              cnt_n[ch]   = '0;
            end else if (cnt_q[ch] + CW'(1) == TICKS_TARGET) begin
              state_n[ch] = ST_HIGH;
              cnt_n[ch]   = '0;
              rise_n[ch]  = 1'b1;
            end else begin
              cnt_n[ch] = cnt_q[ch] + CW'(1);
            end
          end
          ST_HIGH: begin
            if (!lvl_s[ch]) begin
              state_n[ch] = WAIT_LOW;
              cnt_n[ch]   = CW'(1);
            end
          end
          WAIT_LOW: begin
            if (lvl_s[ch]) begin
              state_n[ch] = ST_HIGH;
              cnt_n[ch]   = '0;
            end else if (cnt_q[ch] + CW'(1) == TICKS_TARGET) begin
              state_n[ch] = ST_LOW;
              cnt_n[ch]   = '0;
              fall_n[ch]  = 1'b1;
            end else begin
              cnt_n[ch] = cnt_q[ch] + CW'(1);
            end
          end
          default: begin
            state_n[ch] = RESET_STATE;
            cnt_n[ch]   = '0;
          end
        endcase
      end
      curr_n[ch] = (state_n[ch] == ST_HIGH) || (state_n[ch] == WAIT_LOW);
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Testbench for multi_debouncer: run-length reference model feeding a
// scoreboard queue, with directed scenarios followed by random traffic.
module tb_multi_debouncer;

  localparam int N_CH         = 2;
  localparam int STABLE_TICKS = 4;
  localparam bit RESET_LEVEL  = 1'b0;

  typedef struct {
    logic [N_CH-1:0] curr;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            any;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            m_tick;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] curr_level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            any_change;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cycle_cnt = 0;

  int rise_cnt [N_CH];
  int fall_cnt [N_CH];
  int any_cnt = 0;

  logic [N_CH-1:0] model_sync1;
  logic [N_CH-1:0] model_sync2;
  logic [N_CH-1:0] model_acc;
  int              model_run [N_CH];

  multi_debouncer #(
    .N_CH(N_CH),
    .STABLE_TICKS(STABLE_TICKS),
    .RESET_LEVEL(RESET_LEVEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m_tick(m_tick),
    .level(level),
    .curr_level(curr_level),
    .rise(rise),
    .fall(fall),
    .any_change(any_change)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle_cnt);
    end
  endtask

  // Reference: a level is accepted once the synchronized sample has differed
  // from the accepted level on STABLE_TICKS ticks in a row.
  task automatic modelStep(input logic rst_n, input logic tick, input logic [N_CH-1:0] lvl);
    exp_t e;
    e.rise = '0;
    e.fall = '0;
    if (!rst_n) begin
      model_sync1 = {N_CH{RESET_LEVEL}};
      model_sync2 = {N_CH{RESET_LEVEL}};
      model_acc   = {N_CH{RESET_LEVEL}};
      for (int ch = 0; ch < N_CH; ch++) model_run[ch] = 0;
    end else begin
      if (tick) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (model_sync2[ch] != model_acc[ch]) begin
            model_run[ch] = model_run[ch] + 1;
            if (model_run[ch] == STABLE_TICKS) begin
              model_acc[ch] = model_sync2[ch];
              model_run[ch] = 0;
              if (model_acc[ch]) e.rise[ch] = 1'b1;
              else               e.fall[ch] = 1'b1;
            end
          end else begin
            model_run[ch] = 0;
          end
        end
      end
      model_sync2 = model_sync1;
      model_sync1 = lvl;
    end
    e.curr = model_acc;
    e.any  = |(e.rise | e.fall);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; returns after the monitor has seen the edge.
  task automatic applyStimulus(input logic rst_n, input logic tick, input logic [N_CH-1:0] lvl);
    @(negedge clk);
    reset  = rst_n;
    m_tick = tick;
    level  = lvl;
    modelStep(rst_n, tick, lvl);
    cycle_cnt++;
    @(posedge clk);
    #2;
  endtask

  // Holds a level until n ticks (one every 10 clocks) have been issued.
  task automatic holdTicks(input logic [N_CH-1:0] lvl, input int n);
    int  seen;
    logic t;
    seen = 0;
    while (seen < n) begin
      t = ((cycle_cnt % 10) == 9);
      applyStimulus(1'b1, t, lvl);
      if (t) seen++;
    end
  endtask

  task automatic doReset(input logic [N_CH-1:0] rst_lvl, input logic [N_CH-1:0] post_lvl);
    repeat (3) applyStimulus(1'b0, ((cycle_cnt % 10) == 9), rst_lvl);
    holdTicks(post_lvl, 1);
  endtask

  // Monitor: pops the expected response for every clock edge and compares.
  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      rise_cnt[ch] = 0;
      fall_cnt[ch] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("curr_level", 32'(curr_level), 32'(e.curr));
        checkOutput("rise", 32'(rise), 32'(e.rise));
        checkOutput("fall", 32'(fall), 32'(e.fall));
        checkOutput("any_change", 32'(any_change), 32'(e.any));
        for (int ch = 0; ch < N_CH; ch++) begin
          if (rise[ch] === 1'b1) rise_cnt[ch]++;
          if (fall[ch] === 1'b1) fall_cnt[ch]++;
        end
        if (any_change === 1'b1) any_cnt++;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [N_CH-1:0] rlvl;
    logic            rtick;
    logic            rrst;

    reset  = 1'b0;
    m_tick = 1'b0;
    level  = '0;

    doReset(2'b11, 2'b00);
    checkOutput("reset_curr", 32'(curr_level), 32'h0);
    checkOutput("reset_rise_cnt0", 32'(rise_cnt[0] + rise_cnt[1]), 32'h0);

    holdTicks(2'b01, 4);
    checkOutput("clean_rise_curr", 32'(curr_level), 32'h1);
    checkOutput("clean_rise_cnt0", 32'(rise_cnt[0]), 32'd1);
    checkOutput("clean_rise_cnt1", 32'(rise_cnt[1]), 32'd0);

    holdTicks(2'b00, 4);
    checkOutput("clean_fall_cnt0", 32'(fall_cnt[0]), 32'd1);

    holdTicks(2'b01, 2);
    holdTicks(2'b00, 1);
    holdTicks(2'b01, 3);
    checkOutput("bounce_no_early", 32'(rise_cnt[0]), 32'd1);
    holdTicks(2'b01, 1);
    checkOutput("bounce_rise", 32'(rise_cnt[0]), 32'd2);
    holdTicks(2'b00, 4);
    checkOutput("bounce_fall", 32'(fall_cnt[0]), 32'd2);

    holdTicks(2'b01, 3);
    holdTicks(2'b00, 2);
    checkOutput("short_pulse_rejected", 32'(rise_cnt[0]), 32'd2);
    checkOutput("short_pulse_curr", 32'(curr_level), 32'h0);

    holdTicks(2'b11, 4);
    checkOutput("both_rise_cnt0", 32'(rise_cnt[0]), 32'd3);
    checkOutput("both_rise_cnt1", 32'(rise_cnt[1]), 32'd1);
    checkOutput("both_any_cnt", 32'(any_cnt), 32'd5);
    holdTicks(2'b01, 4);
    checkOutput("ch1_fall_cnt", 32'(fall_cnt[1]), 32'd1);
    holdTicks(2'b00, 4);
    checkOutput("ch0_fall_cnt", 32'(fall_cnt[0]), 32'd3);

    holdTicks(2'b01, 3);
    doReset(2'b01, 2'b01);
    checkOutput("midcount_reset_curr", 32'(curr_level), 32'h0);
    checkOutput("midcount_reset_rise", 32'(rise_cnt[0]), 32'd3);
    holdTicks(2'b01, 2);
    checkOutput("restart_no_credit", 32'(rise_cnt[0]), 32'd3);
    holdTicks(2'b01, 1);
    checkOutput("restart_rise", 32'(rise_cnt[0]), 32'd4);

    rlvl = 2'b01;
    for (int i = 0; i < 2000; i++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 7) == 0) rlvl[ch] = ~rlvl[ch];
      rtick = ($urandom_range(0, 2) == 0);
      rrst  = ($urandom_range(0, 299) != 0);
      applyStimulus(rrst, rtick, rlvl);
    end

    for (int i = 0; i < 300; i++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 5) == 0) rlvl[ch] = ~rlvl[ch];
      applyStimulus(1'b1, 1'b1, rlvl);
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent debounce channels, legal range 1..32.
REQ-002 Parameter STABLE_TICKS, default 4: consecutive agreeing m_tick samples required to accept a new level, legal range 2..255.
REQ-003 Parameter RESET_LEVEL, default 0: 1-bit value loaded into every channel's accepted level at reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-006 m_tick  input  1  sample strobe; high for one clk per sample period.
REQ-007 level  input  N_CH  raw asynchronous bouncy inputs, one bit per channel.
REQ-008 curr_level  output  N_CH  debounced accepted level per channel, registered.
REQ-009 rise  output  N_CH  one-clk pulse when a channel's curr_level goes 0->1.
REQ-010 fall  output  N_CH  one-clk pulse when a channel's curr_level goes 1->0.
REQ-011 any_change  output  1  registered OR of rise|fall across all channels, same cycle as the pulses.

Function
REQ-012 Each level bit SHALL pass a 2-flop synchronizer; only the synchronized value (lvl_s) is used internally.
REQ-013 Channels SHALL be fully independent; no channel's state SHALL affect another's.
REQ-014 Per-channel FSM states SHALL be: ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW; counter width clog2(STABLE_TICKS+1).
REQ-015 State and counter SHALL change only on clk edges where m_tick=1; with m_tick=0 all state holds.
REQ-016 ST_LOW, tick, lvl_s=1 -> WAIT_HIGH, cnt=1; lvl_s=0 -> stay.
REQ-017 WAIT_HIGH, tick, lvl_s=0 -> ST_LOW, cnt=0 (bounce rejected, no pulse).
REQ-018 WAIT_HIGH, tick, lvl_s=1 -> cnt+1; when cnt+1 = STABLE_TICKS -> ST_HIGH, cnt=0.
REQ-019 ST_HIGH / WAIT_LOW SHALL mirror REQ-016..018 with polarities inverted.
REQ-020 curr_level SHALL be 1 in ST_HIGH and WAIT_LOW, 0 in ST_LOW and WAIT_HIGH.
REQ-021 rise/fall SHALL assert for exactly one clk, the first cycle curr_level shows the new value; never both in one cycle on one channel.
REQ-022 Acceptance latency SHALL be exactly STABLE_TICKS ticks from the first tick that samples the new lvl_s value; lvl_s itself lags level by 2 clk.
REQ-023 A reversal on any tick in a WAIT state SHALL restart the count on the next agreeing tick (no partial credit).
REQ-024 m_tick held high continuously SHALL be legal: every clk is a sample.
REQ-025 Counter SHALL never exceed STABLE_TICKS; no wrap-around.

Reset
REQ-026 While reset=0 at a clk edge: synchronizer flops and curr_level = {N_CH{RESET_LEVEL}}, state = ST_HIGH if RESET_LEVEL else ST_LOW, cnt=0, rise=fall=any_change=0.
REQ-027 Reset SHALL take priority over m_tick and override any WAIT state mid-count; no pulse SHALL be emitted on reset entry or exit.
REQ-028 Channels held at RESET_LEVEL after reset release SHALL produce no pulse.

Verification (N_CH=2, STABLE_TICKS=4, m_tick 1 clk in 10, RESET_LEVEL=0)
REQ-029 Reset 3 clk with level=2'b11 -> curr_level=00, rise=fall=00 throughout and 1 clk after release.
REQ-030 Ch0 steps 0->1 clean -> curr_level[0]=1 and rise[0] pulse on the 4th tick after lvl_s high, rise for 1 clk only; ch1 unchanged.
REQ-031 Ch0 bounce: high 2 ticks, low 1 tick, high 4 ticks -> single rise[0] on 4th tick of final run; no pulse earlier.
REQ-032 Ch0 high for 3 ticks then low -> curr_level[0] stays 0, rise never asserts.
REQ-033 Both channels rise on same tick -> rise=11, any_change=1 for one clk; later ch1 falls cleanly -> fall=10 after 4 ticks.
REQ-034 Reset asserted in WAIT_HIGH at cnt=3 -> curr_level=00, no pulse; count restarts from 1 after release.
